// File: rtl/byte_striping.sv
// Byte striping: distributes a serial symbol stream across LANES lanes, aligning
// COM to lane 0 and padding partial groups with PAD_SYM when the stream stops.
module byte_striping #(
  parameter int         LANES   = 4,
  parameter logic [7:0] PAD_SYM = 8'hF7,
  parameter logic [7:0] COM_SYM = 8'hBC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enb,
  input  logic [7:0]           tx_multiplexada,
  input  logic                 tx_Valid,
  output logic [8*LANES-1:0]   lane_data,
  output logic [LANES-1:0]     lane_k,
  output logic [LANES-1:0]     lane_pad,
  output logic                 lane_valid
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  // One staging slot is kept even for LANES=1 so the arrays never collapse to zero width.
  localparam int SW = (LANES > 1) ? LANES - 1 : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);
  localparam logic [IW-1:0] ZERO_IDX = {IW{1'b0}};
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t                state_r, state_s;
  logic [IW-1:0]         idx_r, idx_s;
  logic [SW-1:0][7:0]    stage_data_r, stage_data_s;
  logic [SW-1:0]         stage_k_r, stage_k_s;

  logic [8*LANES-1:0]    data_s;
  logic [LANES-1:0]      k_s;
  logic [LANES-1:0]      pad_s;
  logic                  valid_s;

  logic [8*LANES-1:0]    pg_data_s;
  logic [LANES-1:0]      pg_k_s;
  logic [LANES-1:0]      pg_pad_s;
  logic                  is_com_s;

  assign is_com_s = enb & ~tx_Valid & (tx_multiplexada == COM_SYM);

  // Partial group: staged lanes below idx, PAD_SYM (K=1) in every lane from idx upward.
  always_comb begin
    pg_data_s = '0;
    pg_k_s    = '0;
    pg_pad_s  = '0;
    for (int i = 0; i < LANES; i++) begin
      pg_data_s[8*i +: 8] = PAD_SYM;
      pg_k_s[i]           = 1'b1;
      pg_pad_s[i]         = 1'b1;
    end
    for (int i = 0; i < SW; i++) begin
      if (IW'(i) < idx_r) begin
        pg_data_s[8*i +: 8] = stage_data_r[i];
        pg_k_s[i]           = stage_k_r[i];
        pg_pad_s[i]         = 1'b0;
      end else begin
        pg_pad_s[i] = pg_pad_s[i];
      end
    end
  end

  // Next-state, staging and output-group selection.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    stage_data_s = stage_data_r;
    stage_k_s    = stage_k_r;
    data_s       = lane_data;
    k_s          = lane_k;
    pad_s        = lane_pad;
    valid_s      = 1'b0;
    case (state_r)
      FLUSH: begin
        data_s  = pg_data_s;
        k_s     = pg_k_s;
        pad_s   = pg_pad_s;
        valid_s = 1'b1;
        idx_s   = ZERO_IDX;
        state_s = FILL;
      end
      FILL: begin
        if (enb) begin
          if (is_com_s && (idx_r != ZERO_IDX)) begin
            data_s          = pg_data_s;
            k_s             = pg_k_s;
            pad_s           = pg_pad_s;
            valid_s         = 1'b1;
            stage_data_s[0] = COM_SYM;
            stage_k_s[0]    = 1'b1;
            idx_s           = ONE_IDX;
          end else if (idx_r == LAST_IDX) begin
            // Every lower lane is staged, so the partial group only lacks the last lane.
            data_s                    = pg_data_s;
            k_s                       = pg_k_s;
            pad_s                     = pg_pad_s;
            data_s[8*(LANES-1) +: 8]  = tx_multiplexada;
            k_s[LANES-1]              = ~tx_Valid;
            pad_s[LANES-1]            = 1'b0;
            valid_s                   = 1'b1;
            idx_s                     = ZERO_IDX;
          end else begin
            stage_data_s[idx_r] = tx_multiplexada;
            stage_k_s[idx_r]    = ~tx_Valid;
            idx_s               = idx_r + ONE_IDX;
          end
        end else if (idx_r != ZERO_IDX) begin
          state_s = FLUSH;
        end else begin
          state_s = FILL;
        end
      end
      default: begin
        state_s = FILL;
        idx_s   = ZERO_IDX;
      end
    endcase
  end

  // State, staging and registered output group.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= FILL;
      idx_r        <= ZERO_IDX;
      stage_data_r <= '0;
      stage_k_r    <= '0;
      lane_data    <= '0;
      lane_k       <= '0;
      lane_pad     <= '0;
      lane_valid   <= 1'b0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      stage_data_r <= stage_data_s;
      stage_k_r    <= stage_k_s;
      lane_data    <= data_s;
      lane_k       <= k_s;
      lane_pad     <= pad_s;
      lane_valid   <= valid_s;
    end
  end

endmodule

// File: tb/tb_byte_striping.sv
// Bench for byte_striping (LANES=4): directed steps then random traffic, all
// checked every cycle against a queue-based model of the striping rules.
module tb_byte_striping;
  localparam int LANES = 4;
  localparam logic [7:0] PAD = 8'hF7;
  localparam logic [7:0] COM = 8'hBC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enb = 1'b0;
  logic [7:0] tx_multiplexada = 8'h00;
  logic tx_Valid = 1'b0;
  logic [8*LANES-1:0] lane_data;
  logic [LANES-1:0] lane_k;
  logic [LANES-1:0] lane_pad;
  logic lane_valid;

  int checks = 0;
  int errors = 0;

  byte_striping #(.LANES(LANES), .PAD_SYM(PAD), .COM_SYM(COM)) dut (
    .clk(clk), .rst(rst), .enb(enb), .tx_multiplexada(tx_multiplexada),
    .tx_Valid(tx_Valid), .lane_data(lane_data), .lane_k(lane_k),
    .lane_pad(lane_pad), .lane_valid(lane_valid)
  );

  always #5 clk = ~clk;

  // Model: symbols waiting to form a group, each {k, byte}.
  logic [8:0] pend[$];
  bit flush_f = 1'b0;
  logic [8*LANES-1:0] exp_data = '0;
  logic [LANES-1:0] exp_k = '0;
  logic [LANES-1:0] exp_pad = '0;
  logic exp_valid = 1'b0;

  task automatic emit();
    for (int i = 0; i < LANES; i++) begin
      if (i < pend.size()) begin
        exp_data[8*i +: 8] = pend[i][7:0];
        exp_k[i] = pend[i][8];
        exp_pad[i] = 1'b0;
      end else begin
        exp_data[8*i +: 8] = PAD;
        exp_k[i] = 1'b1;
        exp_pad[i] = 1'b1;
      end
    end
    exp_valid = 1'b1;
    pend.delete();
  endtask

  task automatic model_edge(input bit e, input logic [7:0] s, input bit v);
    exp_valid = 1'b0;
    if (flush_f) begin
      emit();
      flush_f = 1'b0;
    end else if (e) begin
      if (!v && s == COM && pend.size() != 0) begin
        emit();
        pend.push_back({1'b1, s});
      end else begin
        pend.push_back({~v, s});
        if (pend.size() == LANES) emit();
      end
    end else if (pend.size() != 0) begin
      flush_f = 1'b1;
    end
  endtask

  task automatic model_reset();
    pend.delete();
    flush_f = 1'b0;
    exp_data = '0;
    exp_k = '0;
    exp_pad = '0;
    exp_valid = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    checks++;
    assert (lane_valid === exp_valid) else begin
      errors++;
      $error("FAIL %s lane_valid got %0b want %0b", tag, lane_valid, exp_valid);
    end
    checks++;
    assert (lane_data === exp_data) else begin
      errors++;
      $error("FAIL %s lane_data got %h want %h", tag, lane_data, exp_data);
    end
    checks++;
    assert (lane_k === exp_k) else begin
      errors++;
      $error("FAIL %s lane_k got %b want %b", tag, lane_k, exp_k);
    end
    checks++;
    assert (lane_pad === exp_pad) else begin
      errors++;
      $error("FAIL %s lane_pad got %b want %b", tag, lane_pad, exp_pad);
    end
  endtask

  task automatic check_const(input string tag, input logic [31:0] d, input logic [3:0] k,
                             input logic [3:0] p);
    checks++;
    assert (lane_valid === 1'b1 && lane_data === d && lane_k === k && lane_pad === p) else begin
      errors++;
      $error("FAIL %s got v=%0b d=%h k=%b p=%b want v=1 d=%h k=%b p=%b",
             tag, lane_valid, lane_data, lane_k, lane_pad, d, k, p);
    end
  endtask

  // Called just after a negedge; returns just after the next negedge.
  task automatic cycle(input bit e, input logic [7:0] s, input bit v, input string tag);
    enb = e;
    tx_multiplexada = s;
    tx_Valid = v;
    @(posedge clk);
    if (rst) model_edge(e, s, v);
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  initial begin
    int pulses;
    logic [7:0] s;
    bit e;
    bit v;

    @(negedge clk);
    cycle(1'b0, 8'h00, 1'b1, "reset_hold");
    rst = 1'b1;
    cycle(1'b0, 8'h00, 1'b1, "reset_idle");

    // Basic group and latency
    cycle(1'b1, 8'h11, 1'b1, "g1_a");
    cycle(1'b1, 8'h22, 1'b1, "g1_b");
    cycle(1'b1, 8'h33, 1'b1, "g1_c");
    cycle(1'b1, 8'h44, 1'b1, "g1_d");
    check_const("g1_const", 32'h44332211, 4'b0000, 4'b0000);

    // Back-to-back stream 01..0C
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b1, 8'(i), 1'b1, "stream");
      if (lane_valid) pulses++;
    end
    checks++;
    assert (pulses === 3) else begin
      errors++;
      $error("FAIL stream_pulses got %0d want %0d", pulses, 3);
    end
    check_const("stream_last", 32'h0C0B0A09, 4'b0000, 4'b0000);

    // COM alignment
    cycle(1'b1, 8'hAA, 1'b1, "com_a");
    cycle(1'b1, 8'hBB, 1'b1, "com_b");
    cycle(1'b1, COM, 1'b0, "com_c");
    check_const("com_pad", 32'hF7F7BBAA, 4'b1100, 4'b1100);
    cycle(1'b1, 8'h01, 1'b1, "com_d");
    cycle(1'b1, 8'h02, 1'b1, "com_e");
    cycle(1'b1, 8'h03, 1'b1, "com_f");
    check_const("com_next", 32'h030201BC, 4'b0001, 4'b0000);

    // Flush of a partial group; symbol presented during FLUSH is ignored
    cycle(1'b1, 8'h55, 1'b1, "fl_a");
    cycle(1'b1, 8'h66, 1'b1, "fl_b");
    cycle(1'b1, 8'h77, 1'b1, "fl_c");
    cycle(1'b0, 8'h00, 1'b1, "fl_enter");
    cycle(1'b1, 8'h99, 1'b1, "fl_emit");
    check_const("flush_group", 32'hF7776655, 4'b1000, 4'b1000);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, "fl_idle");

    // Data byte BC is not a COM
    cycle(1'b1, 8'h10, 1'b1, "dbc_a");
    cycle(1'b1, 8'h20, 1'b1, "dbc_b");
    cycle(1'b1, 8'hBC, 1'b1, "dbc_c");
    cycle(1'b1, 8'h30, 1'b1, "dbc_d");
    check_const("data_bc", 32'h30BC2010, 4'b0000, 4'b0000);

    // Asynchronous reset mid-group
    cycle(1'b1, 8'hA1, 1'b1, "rs_a");
    cycle(1'b1, 8'hA2, 1'b1, "rs_b");
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_outputs("async_reset");
    @(negedge clk);
    cycle(1'b1, 8'hA3, 1'b1, "rs_hold");
    rst = 1'b1;
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b1, "rs_after");
    check_const("after_reset", 32'h04030201, 4'b0000, 4'b0000);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      e = ($urandom_range(0, 9) < 7);
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 3) == 0) ? COM : 8'($urandom_range(0, 255));
      cycle(e, s, v, "random");
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, "drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/byte_striping.md
Name: byte_striping

Overview:
- Sits directly downstream of the TX symbol multiplexer.
- Each cycle with enb high it accepts one 8-bit symbol plus its data/control flag, and stripes consecutive symbols across LANES lanes.
- Presents each completed lane group as one registered, parallel word with per-lane K flags to the per-lane encoders.
- Enforces COM alignment to lane 0 and pads partial groups when the stream stops.

Parameters:
- LANES, 4, number of lanes; legal values 1, 2, 4.
- PAD_SYM, 8'hF7, symbol inserted in unfilled lanes; always sent with K=1.
- COM_SYM, 8'hBC, control symbol that must land on lane 0.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low; clears all state immediately while low.
- enb  input  1  symbol-accept strobe; one symbol consumed per cycle while high.
- tx_multiplexada  input  8  symbol from the multiplexer.
- tx_Valid  input  1  1 = data symbol, 0 = control symbol; K flag = ~tx_Valid.
- lane_data  output  8*LANES  striped group; lane i occupies bits [8i+7:8i].
- lane_k  output  LANES  per-lane control flag (1 = K symbol).
- lane_pad  output  LANES  per-lane flag: 1 = lane carries inserted PAD_SYM.
- lane_valid  output  1  one-cycle strobe: lane_data/lane_k/lane_pad hold a new group.

Behaviour:
- Reset (rst low):
  - lane_data=0, lane_k=0, lane_pad=0, lane_valid=0.
  - Lane index idx=0, staging registers cleared, state=FILL.
  - Asynchronous: a partial group is discarded with no flush.
- State:
  - idx counter, width clog2(LANES), minimum 1 bit.
  - LANES-1 staging registers of 8-bit symbol plus K flag.
  - FSM states:
    - FILL: accepting symbols.
    - FLUSH: one-cycle emit of a padded partial group after enb drops.
- Normal accept (FILL, enb=1, symbol not a misaligned COM):
  - Symbol goes to lane idx.
  - If idx<LANES-1: stage it, idx<=idx+1.
  - If idx==LANES-1: on the same edge, register the full group onto outputs with lane_valid=1 and lane_pad=0; idx<=0.
  - Latency: lane_valid is high in the cycle after the edge that accepted the last symbol of the group.
- Back-to-back: with enb held high, lane_valid pulses once every LANES cycles; no bubbles, no stalls.
- COM alignment (enb=1, tx_Valid=0, tx_multiplexada==COM_SYM, idx!=0):
  - On the same edge, emit the staged lanes 0..idx-1.
  - Lanes idx..LANES-1 get PAD_SYM with K=1 and lane_pad=1; lane_valid=1.
  - COM is staged into lane 0; idx<=1.
  - A COM with idx==0 is ordinary.
  - A data byte equal to 8'hBC (tx_Valid=1) is NOT a COM.
- Flush (FILL, enb=0, idx!=0):
  - Go to FLUSH.
  - In FLUSH: emit staged lanes 0..idx-1 with PAD_SYM in lanes idx..LANES-1; lane_valid=1; idx<=0; return to FILL.
  - enb is ignored during the FLUSH cycle; a symbol presented there is not accepted.
- enb=0 with idx==0: no activity; lane_valid=0; outputs hold their last group.
- lane_valid is a single-cycle strobe. lane_data, lane_k and lane_pad hold between strobes.
- LANES=1:
  - Every accepted symbol emits next cycle.
  - COM alignment and flush never pad.
  - FLUSH is never entered.
- Priority on one edge: reset > FLUSH > COM alignment > normal accept.

Test Plan:
- LANES=4, reset released, enb=1, tx_Valid=1, bytes 11,22,33,44 on consecutive cycles:
  - One cycle after 44: lane_valid=1, lane_data=32'h44332211, lane_k=0, lane_pad=0.
  - lane_valid is 0 on the three preceding cycles.
- Continuous stream 01..0C:
  - Exactly three lane_valid pulses, 4 cycles apart.
  - Groups 04030201, 08070605, 0C0B0A09.
- Bytes AA,BB (data), then COM (8'hBC, tx_Valid=0), then 01,02,03 (data):
  - First group 32'hF7F7BBAA, lane_k=4'b1100, lane_pad=4'b1100.
  - Next group 32'h030201BC, lane_k=4'b0001, lane_pad=0.
- Bytes 55,66,77 then enb=0:
  - One FLUSH group 32'hF7776655, lane_k=4'b1000, lane_pad=4'b1000.
  - No further lane_valid while enb stays 0.
- Data byte 8'hBC with tx_Valid=1 at idx=2: no padding; it lands in lane 2 with lane_k bit 2 = 0.
- Assert rst low asynchronously after two accepted bytes:
  - All outputs go to 0 immediately, without waiting for clk.
  - After release, bytes 01..04 produce 32'h04030201 with no trace of the discarded bytes.
